// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus arbiter: state encoding, default phase
// timing, requester index constants and the strobe decode used by the phase
// sequencer.
package rtc_bus_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_GAP1 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_GAP2 = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam int T_PULSE_DEF = 4;
  localparam int T_GAP_DEF   = 2;

  localparam int REQ_INI = 0;
  localparam int REQ_WR  = 1;
  localparam int REQ_RD  = 2;

  typedef struct packed {
    logic cs;
    logic rd;
    logic wr;
    logic a_d;
    logic ad_oe;
  } strobe_t;

  // Strobe levels (active-low cs/rd/wr) for a given phase and direction.
  function automatic strobe_t strobe_for(logic [2:0] st, logic is_wr);
    strobe_t s;
    s = '{cs: 1'b1, rd: 1'b1, wr: 1'b1, a_d: 1'b0, ad_oe: 1'b0};
    case (st)
      ST_ADDR: begin
        s.cs    = 1'b0;
        s.wr    = 1'b0;
        s.ad_oe = 1'b1;
      end
      ST_DATA: begin
        s.cs  = 1'b0;
        s.a_d = 1'b1;
        if (is_wr) begin
          s.wr    = 1'b0;
          s.ad_oe = 1'b1;
        end else begin
          s.rd = 1'b0;
        end
      end
      ST_GAP2: s.a_d = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Signal bundle between the requesters / RTC pins (master side) and the
// arbiter (slave side).
//   req, is_write, addr, wdata : per-requester transaction request
//   done, rdata, busy          : completion pulse, read data, activity flag
//   cs, rd, wr, a_d            : RTC strobes (cs/rd/wr active-low)
//   ad_out, ad_oe, ad_in       : multiplexed address/data bus
interface rtc_bus_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   is_write;
  logic [8*N_REQ-1:0] addr;
  logic [8*N_REQ-1:0] wdata;
  logic [N_REQ-1:0]   done;
  logic [7:0]         rdata;
  logic               busy;
  logic               cs;
  logic               rd;
  logic               wr;
  logic               a_d;
  logic [7:0]         ad_out;
  logic               ad_oe;
  logic [7:0]         ad_in;

  modport master (
    output req, is_write, addr, wdata, ad_in,
    input  done, rdata, busy, cs, rd, wr, a_d, ad_out, ad_oe
  );

  modport slave (
    input  req, is_write, addr, wdata, ad_in,
    output done, rdata, busy, cs, rd, wr, a_d, ad_out, ad_oe
  );
endinterface

// File: rtl/rtc_bus_cycle.sv
// Phase sequencer for one RTC bus transaction: ADDR, GAP1, DATA, GAP2.
//   clk, reset        : clock, async active-low reset
//   start             : launch a transaction (only honoured in IDLE)
//   start_write/addr/wdata : transaction parameters, latched on start
//   ad_in             : bus sample, captured into rdata on the last read DATA cycle
//   finish            : high in the last GAP2 cycle
//   cs, rd, wr, a_d, ad_oe, ad_out : registered strobes and bus drive
//   rdata             : last captured read data
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       start_write,
  input  logic [7:0] start_addr,
  input  logic [7:0] start_wdata,
  input  logic [7:0] ad_in,
  output logic       finish,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       a_d,
  output logic       ad_oe,
  output logic [7:0] ad_out,
  output logic [7:0] rdata
);

  localparam logic [7:0] PULSE_LAST = 8'(T_PULSE - 1);
  localparam logic [7:0] GAP_LAST   = 8'(T_GAP - 1);

  logic [2:0] state;
  logic [2:0] nxt;
  logic [7:0] cnt;
  logic       write_q;
  logic [7:0] wdata_q;
  logic       phase_end;
  strobe_t    stb;

  always_comb begin
    phase_end = 1'b0;
    nxt       = state;
    case (state)
      ST_IDLE: if (start) nxt = ST_ADDR;
      ST_ADDR: begin
        phase_end = (cnt == PULSE_LAST);
        if (phase_end) nxt = ST_GAP1;
      end
      ST_GAP1: begin
        phase_end = (cnt == GAP_LAST);
        if (phase_end) nxt = ST_DATA;
      end
      ST_DATA: begin
        phase_end = (cnt == PULSE_LAST);
        if (phase_end) nxt = ST_GAP2;
      end
      ST_GAP2: begin
        phase_end = (cnt == GAP_LAST);
        if (phase_end) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
    finish = (state == ST_GAP2) && phase_end;
    // Outputs are registered from the next state so they line up with it.
    stb = strobe_for(nxt, write_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      cs      <= 1'b1;
      rd      <= 1'b1;
      wr      <= 1'b1;
      a_d     <= 1'b0;
      ad_oe   <= 1'b0;
      ad_out  <= '0;
      rdata   <= '0;
    end else begin
      state <= nxt;
      // Counter restarts on every state entry and rests at zero in IDLE.
      if ((nxt != state) || (state == ST_IDLE)) cnt <= '0;
      else                                      cnt <= cnt + 8'd1;
      cs    <= stb.cs;
      rd    <= stb.rd;
      wr    <= stb.wr;
      a_d   <= stb.a_d;
      ad_oe <= stb.ad_oe;
      if ((state == ST_IDLE) && start) begin
        write_q <= start_write;
        ad_out  <= start_addr;
      end else if ((state == ST_GAP1) && (nxt == ST_DATA) && write_q) begin
        ad_out <= wdata_q;
      end
      if ((state == ST_DATA) && phase_end && !write_q) rdata <= ad_in;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && start) wdata_q <= start_wdata;
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Fixed-priority arbiter for the shared RTC address/data bus. The lowest
// requesting index wins in IDLE; the granted transaction runs to completion
// in rtc_bus_cycle, then done pulses back to the granted requester.
//   clk   : system clock
//   reset : async active-low reset
//   bus   : requester and RTC pin bundle (slave side)
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input logic               clk,
  input logic               reset,
  rtc_bus_arbiter_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Top-level view: IDLE, sequencer running (entered at ADDR), DONE.
  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pick;
  logic             start;
  logic             finish;
  logic [N_REQ-1:0] done_q;
  logic             busy_q;
  logic [7:0]       sel_addr;
  logic [7:0]       sel_wdata;
  logic             sel_write;

  always_comb begin
    pick = '0;
    // Descending scan so the lowest set index is the last one written.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) pick = IDX_W'(i);
    end
    sel_addr  = bus.addr[8*pick +: 8];
    sel_wdata = bus.wdata[8*pick +: 8];
    sel_write = bus.is_write[pick];
    start     = (state == ST_IDLE) && (|bus.req);
  end

  rtc_bus_cycle #(
    .T_PULSE (T_PULSE),
    .T_GAP   (T_GAP)
  ) u_cycle (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_write (sel_write),
    .start_addr  (sel_addr),
    .start_wdata (sel_wdata),
    .ad_in       (bus.ad_in),
    .finish      (finish),
    .cs          (bus.cs),
    .rd          (bus.rd),
    .wr          (bus.wr),
    .a_d         (bus.a_d),
    .ad_oe       (bus.ad_oe),
    .ad_out      (bus.ad_out),
    .rdata       (bus.rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      idx    <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_ADDR;
            idx    <= pick;
            busy_q <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (finish) begin
            state       <= ST_DONE;
            done_q[idx] <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed testbench for rtc_bus_arbiter: default timing DUT plus a
// T_PULSE=T_GAP=1 DUT sharing clock and reset.
module tb_rtc_bus_arbiter;
  import rtc_bus_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  rtc_bus_arbiter_if #(.N_REQ(3)) bus ();
  rtc_bus_arbiter_if #(.N_REQ(3)) bus1 ();

  rtc_bus_arbiter #(.N_REQ(3), .T_PULSE(4), .T_GAP(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rtc_bus_arbiter #(.N_REQ(3), .T_PULSE(1), .T_GAP(1)) dut_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {cs,rd,wr,a_d,ad_oe} in cycle c after the IDLE sample (c >= 1).
  function automatic logic [4:0] exp_strobe(int c, int tp, int tg, logic wdir);
    if (c <= tp)           return 5'b01001;
    if (c <= tp + tg)      return 5'b11100;
    if (c <= 2*tp + tg)    return wdir ? 5'b01011 : 5'b00110;
    if (c <= 2*tp + 2*tg)  return 5'b11110;
    return 5'b11100;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [25:0] got;
    logic [25:0] got1;
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    tick();
    got  = {bus.cs, bus.rd, bus.wr, bus.a_d, bus.ad_oe, bus.ad_out, bus.done, bus.busy, bus.rdata};
    got1 = {bus1.cs, bus1.rd, bus1.wr, bus1.a_d, bus1.ad_oe, bus1.ad_out, bus1.done, bus1.busy, bus1.rdata};
    n_checks++;
    if (got !== {5'b11100, 8'h00, 3'b000, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state got %h expected %h", got, {5'b11100, 8'h00, 3'b000, 1'b0, 8'h00});
    end
    n_checks++;
    if (got1 !== {5'b11100, 8'h00, 3'b000, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state_fast got %h expected %h", got1, {5'b11100, 8'h00, 3'b000, 1'b0, 8'h00});
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({bus.cs, bus.busy, bus.done} !== 5'b10000) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b expected %b", {bus.cs, bus.busy, bus.done}, 5'b10000);
    end
  endtask

  task automatic test_write();
    logic [4:0] got;
    logic [4:0] exp;
    bus.addr[15:8]  = 8'h21;
    bus.wdata[15:8] = 8'h15;
    bus.is_write[1] = 1'b1;
    bus.req[1]      = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) begin
        // Latched at grant: later changes must not reach the bus.
        bus.addr[15:8]  = 8'hEE;
        bus.wdata[15:8] = 8'hDD;
      end
      if (c <= 12) begin
        got = {bus.cs, bus.rd, bus.wr, bus.a_d, bus.ad_oe};
        exp = exp_strobe(c, 4, 2, 1'b1);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL write_strobes c=%0d got %b expected %b", c, got, exp);
        end
        if (exp[0]) begin
          n_checks++;
          if (bus.ad_out !== ((c <= 4) ? 8'h21 : 8'h15)) begin
            n_fail++;
            $display("FAIL write_ad_out c=%0d got %h expected %h", c, bus.ad_out, (c <= 4) ? 8'h21 : 8'h15);
          end
        end
      end
      n_checks++;
      if (bus.done !== ((c == 13) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("FAIL write_done c=%0d got %b expected %b", c, bus.done, (c == 13) ? 3'b010 : 3'b000);
      end
      n_checks++;
      if (bus.busy !== (c <= 13)) begin
        n_fail++;
        $display("FAIL write_busy c=%0d got %b expected %b", c, bus.busy, c <= 13);
      end
      if (c == 13) bus.req[1] = 1'b0;
    end
  endtask

  task automatic test_read();
    logic [4:0] got;
    logic [4:0] exp;
    bus.addr[23:16] = 8'h22;
    bus.is_write[2] = 1'b0;
    bus.ad_in       = 8'hA5;
    bus.req[2]      = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      bus.ad_in = (c >= 7 && c <= 10) ? 8'h37 : 8'hA5;
      if (c <= 12) begin
        got = {bus.cs, bus.rd, bus.wr, bus.a_d, bus.ad_oe};
        exp = exp_strobe(c, 4, 2, 1'b0);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL read_strobes c=%0d got %b expected %b", c, got, exp);
        end
      end
      if (c == 1) begin
        n_checks++;
        if (bus.ad_out !== 8'h22) begin
          n_fail++;
          $display("FAIL read_addr got %h expected %h", bus.ad_out, 8'h22);
        end
      end
      n_checks++;
      if (bus.done !== ((c == 13) ? 3'b100 : 3'b000)) begin
        n_fail++;
        $display("FAIL read_done c=%0d got %b expected %b", c, bus.done, (c == 13) ? 3'b100 : 3'b000);
      end
      if (c >= 13) begin
        n_checks++;
        if (bus.rdata !== 8'h37) begin
          n_fail++;
          $display("FAIL read_rdata c=%0d got %h expected %h", c, bus.rdata, 8'h37);
        end
      end
      if (c == 13) bus.req[2] = 1'b0;
    end
  endtask

  task automatic test_priority();
    logic [7:0] exp_addr [3];
    logic [2:0] exp_done;
    logic       exp_busy;
    int         k;
    exp_addr[0] = 8'h10;
    exp_addr[1] = 8'h21;
    exp_addr[2] = 8'h22;
    k = 0;
    bus.addr     = {8'h22, 8'h21, 8'h10};
    bus.wdata    = {8'h00, 8'h15, 8'h01};
    bus.is_write = 3'b011;
    bus.ad_in    = 8'h00;
    bus.req      = 3'b111;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (k < 3 && c == 1 + 14*k) begin
        n_checks++;
        if ({bus.cs, bus.ad_out} !== {1'b0, exp_addr[k]}) begin
          n_fail++;
          $display("FAIL prio_grant k=%0d got %h expected %h", k, {bus.cs, bus.ad_out}, {1'b0, exp_addr[k]});
        end
      end
      exp_done = (k < 3 && c == 13 + 14*k) ? 3'(1 << k) : 3'b000;
      exp_busy = (c <= 41) && (c % 14 != 0);
      n_checks++;
      if (bus.done !== exp_done) begin
        n_fail++;
        $display("FAIL prio_done c=%0d got %b expected %b", c, bus.done, exp_done);
      end
      n_checks++;
      if (bus.busy !== exp_busy) begin
        n_fail++;
        $display("FAIL prio_busy c=%0d got %b expected %b", c, bus.busy, exp_busy);
      end
      if (exp_done != 3'b000) begin
        bus.req[k] = 1'b0;
        k++;
      end
    end
    bus.req = 3'b000;
  endtask

  task automatic test_no_preempt();
    logic [4:0] got;
    logic [4:0] exp;
    bus.addr[23:16] = 8'h22;
    bus.is_write[2] = 1'b0;
    bus.ad_in       = 8'hA5;
    bus.req[2]      = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      tick();
      bus.ad_in = (c >= 7 && c <= 10) ? 8'h37 : 8'hA5;
      if (c == 8) begin
        bus.addr[7:0]   = 8'h10;
        bus.wdata[7:0]  = 8'h5A;
        bus.is_write[0] = 1'b1;
        bus.req[0]      = 1'b1;
      end
      if (c <= 12) begin
        got = {bus.cs, bus.rd, bus.wr, bus.a_d, bus.ad_oe};
        exp = exp_strobe(c, 4, 2, 1'b0);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL nopre_strobes c=%0d got %b expected %b", c, got, exp);
        end
      end
      if (c == 13) begin
        n_checks++;
        if (bus.rdata !== 8'h37) begin
          n_fail++;
          $display("FAIL nopre_rdata got %h expected %h", bus.rdata, 8'h37);
        end
      end
      if (c == 14 || c == 15) begin
        n_checks++;
        if ({bus.cs, bus.busy} !== ((c == 14) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL nopre_idle c=%0d got %b expected %b", c, {bus.cs, bus.busy}, (c == 14) ? 2'b10 : 2'b01);
        end
      end
      if (c == 15) begin
        n_checks++;
        if (bus.ad_out !== 8'h10) begin
          n_fail++;
          $display("FAIL nopre_next_grant got %h expected %h", bus.ad_out, 8'h10);
        end
      end
      n_checks++;
      if (bus.done !== ((c == 13) ? 3'b100 : (c == 27) ? 3'b001 : 3'b000)) begin
        n_fail++;
        $display("FAIL nopre_done c=%0d got %b expected %b", c, bus.done, (c == 13) ? 3'b100 : (c == 27) ? 3'b001 : 3'b000);
      end
      if (c == 13) bus.req[2] = 1'b0;
      if (c == 27) bus.req[0] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] got;
    bus.addr[15:8]  = 8'h21;
    bus.wdata[15:8] = 8'h15;
    bus.is_write[1] = 1'b1;
    bus.req[1]      = 1'b1;
    for (int c = 1; c <= 8; c++) tick();
    n_checks++;
    if ({bus.cs, bus.wr, bus.a_d} !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_in_data got %b expected %b", {bus.cs, bus.wr, bus.a_d}, 3'b001);
    end
    #2 reset = 1'b0;
    #1;
    got = {bus.cs, bus.rd, bus.wr, bus.a_d, bus.ad_oe, bus.ad_out, bus.done, bus.busy, bus.rdata};
    n_checks++;
    if (got !== {5'b11100, 8'h00, 3'b000, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rstmid_async got %h expected %h", got, {5'b11100, 8'h00, 3'b000, 1'b0, 8'h00});
    end
    tick();
    tick();
    n_checks++;
    if ({bus.done, bus.busy, bus.cs} !== 5'b00001) begin
      n_fail++;
      $display("FAIL rstmid_held got %b expected %b", {bus.done, bus.busy, bus.cs}, 5'b00001);
    end
    reset = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) begin
        n_checks++;
        if ({bus.cs, bus.wr, bus.a_d, bus.ad_out} !== {3'b000, 8'h21}) begin
          n_fail++;
          $display("FAIL rstmid_restart got %h expected %h", {bus.cs, bus.wr, bus.a_d, bus.ad_out}, {3'b000, 8'h21});
        end
      end
      n_checks++;
      if (bus.done !== ((c == 13) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("FAIL rstmid_done c=%0d got %b expected %b", c, bus.done, (c == 13) ? 3'b010 : 3'b000);
      end
      if (c == 13) bus.req[1] = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got;
    logic [4:0] exp;
    bus1.addr[15:8]  = 8'h21;
    bus1.wdata[15:8] = 8'h15;
    bus1.is_write[1] = 1'b1;
    bus1.req[1]      = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)) begin
        got = {bus1.cs, bus1.rd, bus1.wr, bus1.a_d, bus1.ad_oe};
        exp = exp_strobe((c <= 4) ? c : c - 6, 1, 1, 1'b1);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL fast_strobes c=%0d got %b expected %b", c, got, exp);
        end
      end
      if (c == 1 || c == 7) begin
        n_checks++;
        if (bus1.ad_out !== 8'h21) begin
          n_fail++;
          $display("FAIL fast_addr c=%0d got %h expected %h", c, bus1.ad_out, 8'h21);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (bus1.ad_out !== 8'h15) begin
          n_fail++;
          $display("FAIL fast_wdata got %h expected %h", bus1.ad_out, 8'h15);
        end
      end
      n_checks++;
      if (bus1.done !== ((c == 5 || c == 11) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("FAIL fast_done c=%0d got %b expected %b", c, bus1.done, (c == 5 || c == 11) ? 3'b010 : 3'b000);
      end
      n_checks++;
      if (bus1.busy !== ((c >= 1 && c <= 5) || (c >= 7 && c <= 11))) begin
        n_fail++;
        $display("FAIL fast_busy c=%0d got %b expected %b", c, bus1.busy, (c >= 1 && c <= 5) || (c >= 7 && c <= 11));
      end
      if (c == 11) bus1.req[1] = 1'b0;
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    bus.req       = '0;
    bus.is_write  = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.ad_in     = '0;
    bus1.req      = '0;
    bus1.is_write = '0;
    bus1.addr     = '0;
    bus1.wdata    = '0;
    bus1.ad_in    = '0;
    test_reset();
    test_write();
    test_read();
    test_priority();
    test_no_preempt();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Shares the RTC multiplexed address/data bus between three requesters: initialization, configuration write and periodic time read. Each requester gets exclusive use of one complete bus transaction. Requests are served by fixed-priority arbitration. The granted transaction is sequenced as an address phase followed by a data phase, producing the RTC control strobes cs, rd, wr and a_d. The block sits between the RTC-facing pins and the init/write/read sequencers, and replaces their direct drive of the strobes.

## Interface
- N_REQ, 3, number of requesters; index 0 is highest priority.
- T_PULSE, 4, clock cycles a strobe stays active in each phase; legal range 1..255.
- T_GAP, 2, clock cycles of all strobes inactive after each phase; legal range 1..255.

- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- req  input  N_REQ  per-requester transaction request, level.
- is_write  input  N_REQ  per-requester direction: 1 = write, 0 = read.
- addr  input  8*N_REQ  per-requester RTC register address; requester i uses bits [8i+7:8i].
- wdata  input  8*N_REQ  per-requester write data, same packing as addr.
- done  output  N_REQ  one-cycle pulse to the requester whose transaction completed.
- rdata  output  8  read data; valid in the done cycle and held until the next read capture.
- busy  output  1  high from grant until the done cycle, inclusive.
- cs, rd, wr  output  1 each  RTC strobes, active-low.
- a_d  output  1  phase select: 0 = address phase, 1 = data phase.
- ad_out  output  8  bus drive value.
- ad_oe  output  1  bus drive enable for the tristate at the top level.
- ad_in  input  8  bus sample value.

## Operation
- States: IDLE, ADDR, GAP1, DATA, GAP2, DONE.
- IDLE: if any req bit is set, grant the lowest set index. Latch that requester's index, direction, addr and wdata, then go to ADDR. Otherwise stay in IDLE.
- ADDR, T_PULSE cycles: cs=0, wr=0, rd=1, a_d=0, ad_oe=1, ad_out = latched addr.
- GAP1, T_GAP cycles: cs=rd=wr=1, a_d=0, ad_oe=0.
- DATA, T_PULSE cycles: cs=0, a_d=1, and then by direction:
  - write: wr=0, rd=1, ad_oe=1, ad_out = latched wdata.
  - read: rd=0, wr=1, ad_oe=0. ad_in is captured into rdata on the last DATA cycle.
- GAP2, T_GAP cycles: cs=rd=wr=1, a_d=1, ad_oe=0.
- DONE, 1 cycle: done[granted]=1, then go to IDLE.
- A single 8-bit phase counter clears on every state entry. A phase ends when the counter equals the phase length minus 1; no wrap is possible.
- Requests are never preempted. Requests arriving mid-transaction wait for the next IDLE.
- A requester deasserting req mid-transaction does not abort it; done still pulses.
- Requesters must hold addr, wdata and is_write stable only until the grant cycle, since these are latched at grant.
- Requesters must deassert req in the cycle after done. A req still high in IDLE starts a new transaction.
- Fixed priority allows starvation of index 2; this is accepted because init and write are rare.
- Reset values: cs=rd=wr=1, a_d=0, ad_oe=0, ad_out=0, done=0, busy=0, rdata=0, state IDLE.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronous). No done pulse is issued and the transaction is lost.

## Timing
- Grant latency: 0. The req seen in IDLE at edge k puts the block in ADDR in cycle k+1.
- Transaction length from the IDLE cycle that samples req to the done cycle: 1 + 2·T_PULSE + 2·T_GAP cycles. With defaults this is 13; with T_PULSE=T_GAP=1 it is 5.
- Between consecutive transactions there is at least 1 IDLE cycle (the DONE → IDLE transition).
- All outputs are registered; no combinational path exists from req to any strobe.

## Structure
- Package rtc_bus_pkg holds:
  - state encoding;
  - default T_PULSE and T_GAP;
  - requester index constants REQ_INI=0, REQ_WR=1, REQ_RD=2.
- Sub-module rtc_bus_cycle: the phase sequencer (ADDR/GAP1/DATA/GAP2 with its counter, strobes and read capture). It has a start/finish handshake.
- Top level rtc_bus_arbiter: the priority arbiter, request latch, done steering and busy.

## Test plan
- Write via req[1] with addr=0x21, wdata=0x15 → a_d=0 and wr=0 for 4 cycles with ad_out=0x21, then 2 idle cycles, then wr=0 for 4 cycles with ad_out=0x15 and ad_oe=1. done[1] pulses 13 cycles after the IDLE sample.
- Read via req[2] with addr=0x22 and ad_in=0x37 during DATA → rd=0 and ad_oe=0 in DATA. rdata=0x37 in the done[2] cycle and held afterwards.
- req[0], req[1], req[2] asserted in the same cycle, each dropped after its done → served in order 0, 1, 2. Three done pulses are 14 cycles apart, each separated by one IDLE cycle.
- req[0] raised during the DATA phase of a req[2] read → the read completes unchanged and done[2] pulses, then req[0] is granted in the following IDLE.
- reset driven to 0 during DATA of a write → cs=wr=1, ad_oe=0 and busy=0 without waiting for clk, and no done. After release with req[1] still high, the transaction restarts from ADDR.
- T_PULSE=1, T_GAP=1 → each phase lasts 1 cycle, done arrives at cycle 5, and back-to-back requests show exactly 1 IDLE cycle between them.
